// File: rtl/banco_pkg.sv
// rtl/banco_pkg.sv - shared constants, clear-FSM states and byte-merge helper for the register bank
package banco_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } clr_state_t;

    // One byte lane of a masked write; shared by the write path and the bypass path.
    function automatic logic [7:0] byte_merge(input logic [7:0] old_byte,
                                              input logic [7:0] new_byte,
                                              input logic       be);
        return be ? new_byte : old_byte;
    endfunction

endpackage

// File: rtl/banco_clear_ctrl.sv
// rtl/banco_clear_ctrl.sv - bulk-clear FSM, entry counter, busy and write gating
module banco_clear_ctrl
    import banco_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_req,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    output logic              busy,
    output logic              wr_accept,
    output logic              wr_drop,
    output logic              clr_en,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LAST_ENTRY = '1;
    localparam logic [ADDR_W-1:0] CNT_ONE    = {{(ADDR_W-1){1'b0}}, 1'b1};

    clr_state_t        r_state;
    clr_state_t        w_state_next;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_cnt_next;
    logic              r_wr_drop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_wr_drop <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_wr_drop <= wr_en & busy;
        end
    end

    // Terminal count is compared explicitly so the wrapping counter never re-clears entry 0.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (clr_req) begin
                    w_state_next = ST_CLEAR;
                    w_cnt_next   = '0;
                end
            end
            ST_CLEAR: begin
                w_cnt_next = r_cnt + CNT_ONE;
                if (r_cnt == LAST_ENTRY) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign busy      = (r_state == ST_CLEAR);
    assign clr_en    = busy;
    assign clr_addr  = r_cnt;
    assign wr_drop   = r_wr_drop;
    assign wr_accept = wr_en & ~busy & ~((ZERO_REG != 0) && (wr_addr == '0));

endmodule

// File: rtl/banco_registros_param.sv
// rtl/banco_registros_param.sv - parametrised register bank with byte-masked write, bypass and bulk clear
module banco_registros_param
    import banco_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int N_READ   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_READ*ADDR_W-1:0] rd_addr,
    output logic [N_READ*DATA_W-1:0] rd_data,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [DATA_W/8-1:0]      wr_be,
    input  logic                     clr_req,
    output logic                     busy,
    output logic                     wr_drop
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NB    = DATA_W / 8;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] w_wr_word;
    logic              w_wr_accept;
    logic              w_clr_en;
    logic [ADDR_W-1:0] w_clr_addr;

    banco_clear_ctrl #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_clear_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_req   (clr_req),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .busy      (busy),
        .wr_accept (w_wr_accept),
        .wr_drop   (wr_drop),
        .clr_en    (w_clr_en),
        .clr_addr  (w_clr_addr)
    );

    always_comb begin
        w_wr_word = '0;
        for (int b = 0; b < NB; b++) begin
            w_wr_word[b*8 +: 8] = byte_merge(r_mem[wr_addr][b*8 +: 8], wr_data[b*8 +: 8], wr_be[b]);
        end
    end

    // Writes are already gated off while clearing, so the clear never competes with a write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_clr_en) begin
            r_mem[w_clr_addr] <= '0;
        end else if (w_wr_accept) begin
            r_mem[wr_addr] <= w_wr_word;
        end
    end

    for (genvar p = 0; p < N_READ; p++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        logic [DATA_W-1:0] w_data;

        assign w_addr = rd_addr[p*ADDR_W +: ADDR_W];

        always_comb begin
            if ((ZERO_REG != 0) && (w_addr == '0)) begin
                w_data = '0;
            end else if ((BYPASS != 0) && w_wr_accept && (wr_addr == w_addr)) begin
                w_data = w_wr_word;
            end else begin
                w_data = r_mem[w_addr];
            end
        end

        assign rd_data[p*DATA_W +: DATA_W] = w_data;
    end

endmodule

// File: tb/tb_banco_registros_param.sv
// tb/tb_banco_registros_param.sv - directed self-checking bench for banco_registros_param
module tb_banco_registros_param;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic        clr_req;
    logic        busy;
    logic        wr_drop;

    int total = 0;
    int bad   = 0;

    banco_registros_param #(
        .DATA_W   (32),
        .ADDR_W   (5),
        .N_READ   (2),
        .ZERO_REG (1),
        .BYPASS   (1)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .wr_be   (wr_be),
        .clr_req (clr_req),
        .busy    (busy),
        .wr_drop (wr_drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [4:0] a0, input logic [4:0] a1,
                      output logic [31:0] d0, output logic [31:0] d1);
        rd_addr = {a1, a0};
        #1;
        d0 = rd_data[31:0];
        d1 = rd_data[63:32];
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        wr_be   = be;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    function automatic logic [31:0] fill_val(input int i);
        return 32'h1000_0000 + i * 32'h111;
    endfunction

    logic [31:0] d0, d1;
    int          busy_cnt;

    initial begin
        rst_n   = 1'b0;
        rd_addr = '0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        wr_be   = '0;
        clr_req = 1'b0;

        // Reset state
        #2;
        for (int a = 0; a < 32; a += 2) begin
            rd(5'(a), 5'(a + 1), d0, d1);
            chk($sformatf("reset_rd_r%0d", a), d0, 32'h0);
            chk($sformatf("reset_rd_r%0d", a + 1), d1, 32'h0);
        end
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_wr_drop", 32'(wr_drop), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Full and partial writes
        wr(5'd5, 32'hDEAD_BEEF, 4'hF);
        rd(5'd5, 5'd5, d0, d1);
        chk("wr_full_p0", d0, 32'hDEAD_BEEF);
        chk("wr_full_p1", d1, 32'hDEAD_BEEF);
        wr(5'd5, 32'h0000_00AA, 4'h1);
        rd(5'd5, 5'd5, d0, d1);
        chk("wr_be1_p0", d0, 32'hDEAD_BEAA);
        wr(5'd5, 32'h5566_7788, 4'hA);
        rd(5'd5, 5'd5, d0, d1);
        chk("wr_beA_p1", d1, 32'h55AD_77AA);

        // Zero register
        wr(5'd0, 32'h1234_5678, 4'hF);
        rd(5'd0, 5'd5, d0, d1);
        chk("zero_reg", d0, 32'h0);

        // Bypass: same-cycle write visible before the edge
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = 5'd7;
        wr_data = 32'hCAFE_F00D;
        wr_be   = 4'hF;
        rd(5'd7, 5'd5, d0, d1);
        chk("bypass_p0", d0, 32'hCAFE_F00D);
        chk("bypass_other_p1", d1, 32'h55AD_77AA);
        @(negedge clk);
        wr_en = 1'b0;
        rd(5'd7, 5'd7, d0, d1);
        chk("bypass_stored", d1, 32'hCAFE_F00D);

        // Fill r1..r31, then bulk clear
        for (int i = 1; i < 32; i++) wr(5'(i), fill_val(i), 4'hF);
        @(negedge clk);
        clr_req = 1'b1;
        @(negedge clk);
        clr_req  = 1'b0;
        busy_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (busy) busy_cnt++;
            if (c == 4) begin
                rd(5'd3, 5'd30, d0, d1);
                chk("mid_clear_r3", d0, 32'h0);
                chk("mid_clear_r30", d1, fill_val(30));
                wr_en   = 1'b1;
                wr_addr = 5'd9;
                wr_data = 32'hBAD0_0009;
                wr_be   = 4'hF;
                rd(5'd9, 5'd9, d0, d1);
                chk("clear_no_bypass", d1, fill_val(9));
            end
            if (c == 5) begin
                wr_en = 1'b0;
                chk("drop_pulse", 32'(wr_drop), 32'h1);
                rd(5'd9, 5'd9, d0, d1);
                chk("drop_r9_kept", d0, fill_val(9));
            end
            if (c == 6) chk("drop_one_cycle", 32'(wr_drop), 32'h0);
            @(negedge clk);
        end
        chk("clear_busy_cycles", 32'(busy_cnt), 32'd32);
        chk("clear_busy_low", 32'(busy), 32'h0);
        for (int a = 0; a < 32; a += 2) begin
            rd(5'(a), 5'(a + 1), d0, d1);
            chk($sformatf("post_clear_r%0d", a), d0, 32'h0);
            chk($sformatf("post_clear_r%0d", a + 1), d1, 32'h0);
        end

        // Write and clear requested together in IDLE
        wr(5'd9, 32'h0000_0099, 4'hF);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = 5'd9;
        wr_data = 32'h0000_0055;
        wr_be   = 4'hF;
        clr_req = 1'b1;
        @(negedge clk);
        wr_en   = 1'b0;
        clr_req = 1'b0;
        chk("simul_busy", 32'(busy), 32'h1);
        rd(5'd9, 5'd9, d0, d1);
        chk("simul_r9_written", d0, 32'h0000_0055);
        busy_cnt = 0;
        while (busy && busy_cnt < 100) begin
            @(negedge clk);
            busy_cnt++;
        end
        chk("simul_busy_fell", 32'(busy), 32'h0);
        rd(5'd9, 5'd9, d0, d1);
        chk("simul_r9_cleared", d0, 32'h0);
        chk("simul_no_drop", 32'(wr_drop), 32'h0);

        // Reset mid-clear
        wr(5'd2, 32'h0000_0022, 4'hF);
        wr(5'd30, 32'h3030_3030, 4'hF);
        @(negedge clk);
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", 32'(busy), 32'h0);
        rd(5'd2, 5'd30, d0, d1);
        chk("rst_mid_r2", d0, 32'h0);
        chk("rst_mid_r30", d1, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        wr(5'd2, 32'h0202_0202, 4'hF);
        rd(5'd2, 5'd2, d0, d1);
        chk("post_rst_wr_r2", d0, 32'h0202_0202);
        chk("post_rst_busy", 32'(busy), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/banco_registros_param.md
# banco_registros_param

Parametrised, clocked register file: the next-generation general-purpose register bank for the datapath. It provides a configurable number of combinational read ports, one synchronous byte-masked write port with optional write-to-read bypass, optional hardwired-zero register 0, and a sequential bulk-clear engine that zeroes the whole bank one entry per cycle. It sits between instruction decode (read addresses) and writeback (write port).

## Interface
- DATA_W, 32: register width in bits; must be a multiple of 8.
- ADDR_W, 5: address width; DEPTH = 2**ADDR_W entries.
- N_READ, 2: number of read ports, 1..4.
- ZERO_REG, 1: when 1, entry 0 always reads 0 and ignores writes.
- BYPASS, 1: when 1, a same-cycle accepted write is forwarded to matching read ports.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- rd_addr  in  N_READ*ADDR_W  packed read addresses; port i uses bits [i*ADDR_W +: ADDR_W].
- rd_data  out  N_READ*DATA_W  packed read data; port i uses bits [i*DATA_W +: DATA_W].
- wr_en  in  1  write request.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- wr_be  in  DATA_W/8  byte enables; byte b is updated only when wr_be[b]=1.
- clr_req  in  1  request a bulk clear.
- busy  out  1  clear engine active.
- wr_drop  out  1  one-cycle pulse: a write was rejected because a clear was in progress.

## Operation
- Storage: DEPTH x DATA_W flops. An accepted write updates the enabled bytes at the rising edge.
- Write accepted when wr_en=1, busy=0, and not (ZERO_REG=1 and wr_addr=0).
- Reads are combinational from storage. The first matching rule applies:
  - ZERO_REG=1 and address 0: returns 0.
  - BYPASS=1, the write is accepted, and wr_addr equals the read address: returns the stored word with the enabled bytes replaced by wr_data.
  - Otherwise: returns the stored word.
- Clear FSM, two states:
  - IDLE: clr_req=1 moves to CLEAR and loads the counter with 0.
  - CLEAR: busy=1. Each cycle the entry at the counter is zeroed and the counter increments. At counter=DEPTH-1 that entry is zeroed and the FSM returns to IDLE.
  - clr_req is ignored while in CLEAR.
- Writes during CLEAR are dropped and set wr_drop=1 on the next cycle. The bypass is inactive during CLEAR.
- Simultaneous wr_en and clr_req in IDLE: the write is accepted at that edge, and the clear then erases it.
- Reads during CLEAR return the current storage: already-cleared entries read 0, not-yet-cleared entries keep their old value.
- Counter width is ADDR_W. The terminal count is detected explicitly, so wrap-around never re-clears an entry.

## Timing
- Reset (rst_n=0, asynchronous): all entries become 0, FSM goes to IDLE, busy=0, wr_drop=0. rd_data therefore reads 0 on all ports.
- Reset during CLEAR aborts it immediately. The bank is fully zeroed by the reset itself.
- Write latency: 1 edge to storage, 0 cycles to a read port when BYPASS=1. With BYPASS=0 the new value is visible the cycle after the edge.
- Clear: busy rises the cycle after clr_req is sampled and stays high for exactly DEPTH cycles. The first write accepted after a clear is the one presented in the cycle busy is low again.
- wr_drop is registered: it is high for exactly the cycle after each rejected write.

## Structure
- Shared package `banco_pkg` holds:
  - the default DATA_W and ADDR_W constants;
  - the clear-FSM state enum (ST_IDLE, ST_CLEAR);
  - a byte-merge function (old, new, be), used by both the write path and the bypass path.
- Natural sub-module: `banco_clear_ctrl`, which contains the FSM, the counter, busy, and the write-gating signal.
- Storage, write-merge and read muxing stay in the top module.

## Test plan
- Reset then read: with rst_n low, addresses 0..31 read 0x00000000; busy=0, wr_drop=0.
- Write/read: write 0xDEADBEEF to r5 with wr_be=4'hF, then read r5 on both ports -> 0xDEADBEEF. Write 0x000000AA to r5 with wr_be=4'h1 -> r5 reads 0xDEADBEAA.
- Zero register and bypass: write 0x12345678 to r0 -> r0 reads 0. Same cycle, write 0xCAFEF00D to r7 while rd_addr0=7 -> rd_data0=0xCAFEF00D before the edge.
- Clear sequence:
  - Fill r1..r31 with nonzero values, then pulse clr_req -> busy high for 32 cycles.
  - Mid-clear, r3 reads 0 once cleared while r30 still holds its value.
  - After busy falls, every entry reads 0.
- Write during clear: wr_en to r9 at clear cycle 4 -> r9 unchanged, wr_drop=1 for one cycle. Simultaneous wr_en to r9 and clr_req in IDLE -> r9 ends at 0.
- Reset mid-clear: assert rst_n=0 at clear cycle 10 -> busy=0 immediately and all entries read 0. After release, a write to r2 succeeds.
